// File: rtl/oram_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : oram_request_scheduler                                       |
// | Description : Front-end for the ORAM core. Client requests are queued in a |
// |               small FIFO and issued to the core one at a time, each as a   |
// |               single-cycle oram_input_ready pulse. The core result is      |
// |               returned to the client as a tagged valid/ready response.     |
// | Ports       : clk, rst (async, active-high)                                |
// |               req_*  : client request channel (valid/ready)                |
// |               resp_* : client response channel (valid/ready)               |
// |               oram_* : ORAM core interface                                 |
// | Options     : ORAM_DUMMY_EN - after 8 idle cycles, issue a dummy read of   |
// |               block 0 that produces no client response.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module oram_request_scheduler #(
  parameter int D     = 4,
  parameter int A     = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [D-1:0]     req_addr,
  input  logic [8*A-1:0]   req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_rw,
  output logic [TAG_W-1:0] resp_tag,
  output logic [8*A-1:0]   resp_rdata,
  output logic [D-1:0]     oram_block_number,
  output logic [8*A-1:0]   oram_w_value,
  output logic             oram_rw_indicator,
  output logic             oram_input_ready,
  input  logic [8*A-1:0]   oram_r_value,
  input  logic             oram_output_ready
);

  localparam int c_DW = 8 * A;
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = 1 + D + c_DW + TAG_W;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [c_EW-1:0]  r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_head_rw;
  logic [D-1:0]     w_head_addr;
  logic [c_DW-1:0]  w_head_wdata;
  logic [TAG_W-1:0] w_head_tag;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  // A full FIFO refuses a push even when the head is popped on the same edge.
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  assign {w_head_rw, w_head_addr, w_head_wdata, w_head_tag} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_rw, req_addr, req_wdata, req_tag};
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Obliviousness padding
  // ---------------------------------------------------------------------------
  logic w_dummy_go;
  logic r_dummy;    // operation in flight is a padding read

`ifdef ORAM_DUMMY_EN
  logic [2:0] r_idle_cnt;

  // Counts completed idle cycles; the 8th consecutive one launches the dummy.
  // Any issue, or any non-idle cycle, restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_empty && !w_dummy_go) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end else begin
      r_idle_cnt <= '0;
    end
  end

  assign w_dummy_go = (r_state == S_IDLE) && w_empty && (r_idle_cnt == 3'd7);
`else
  assign w_dummy_go = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop || w_dummy_go) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (oram_output_ready) w_next = r_dummy ? S_IDLE : S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Core-side and response registers
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] r_tag;

  // The oram_* fields are loaded only when leaving IDLE, so they hold steady
  // through ISSUE and WAIT as the core requires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oram_block_number <= '0;
      oram_w_value      <= '0;
      oram_rw_indicator <= 1'b0;
      oram_input_ready  <= 1'b0;
      r_tag             <= '0;
      r_dummy           <= 1'b0;
      resp_valid        <= 1'b0;
      resp_rw           <= 1'b0;
      resp_tag          <= '0;
      resp_rdata        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            oram_block_number <= w_head_addr;
            oram_w_value      <= w_head_wdata;
            oram_rw_indicator <= w_head_rw;
            oram_input_ready  <= 1'b1;
            r_tag             <= w_head_tag;
            r_dummy           <= 1'b0;
          end else if (w_dummy_go) begin
            oram_block_number <= '0;
            oram_w_value      <= '0;
            oram_rw_indicator <= 1'b0;
            oram_input_ready  <= 1'b1;
            r_dummy           <= 1'b1;
          end
        end
        S_ISSUE: oram_input_ready <= 1'b0;
        S_WAIT: begin
          if (oram_output_ready && !r_dummy) begin
            resp_valid <= 1'b1;
            resp_rw    <= oram_rw_indicator;
            resp_tag   <= r_tag;
            resp_rdata <= oram_rw_indicator ? '0 : oram_r_value;
          end
        end
        S_RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oram_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_oram_request_scheduler                                    |
// | Description : Self-checking bench for oram_request_scheduler with a simple |
// |               ORAM core model and an in-order response reference model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_oram_request_scheduler;

  localparam int D     = 4;
  localparam int A     = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int DW    = 8 * A;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [D-1:0]     req_addr;
  logic [DW-1:0]    req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_rw;
  logic [TAG_W-1:0] resp_tag;
  logic [DW-1:0]    resp_rdata;
  logic [D-1:0]     oram_block_number;
  logic [DW-1:0]    oram_w_value;
  logic             oram_rw_indicator;
  logic             oram_input_ready;
  logic [DW-1:0]    oram_r_value;
  logic             oram_output_ready;

  always #5 clk = ~clk;

  oram_request_scheduler #(.D(D), .A(A), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rw            (req_rw),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_tag           (req_tag),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rw           (resp_rw),
    .resp_tag          (resp_tag),
    .resp_rdata        (resp_rdata),
    .oram_block_number (oram_block_number),
    .oram_w_value      (oram_w_value),
    .oram_rw_indicator (oram_rw_indicator),
    .oram_input_ready  (oram_input_ready),
    .oram_r_value      (oram_r_value),
    .oram_output_ready (oram_output_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // ORAM core model: samples on input_ready, answers core_lat cycles later
  // ---------------------------------------------------------------------------
  int            core_lat  = 0;
  int            n_issue   = 0;
  int            pulse_err = 0;
  int            stab_err  = 0;
  logic [DW-1:0] core_mem [16] = '{default: '0};
  logic          c_busy, c_rw, prev_ir;
  logic [D-1:0]  c_addr;
  int            c_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy            <= 1'b0;
      c_rw              <= 1'b0;
      c_addr            <= '0;
      c_cnt             <= 0;
      prev_ir           <= 1'b0;
      oram_output_ready <= 1'b0;
      oram_r_value      <= '0;
    end else begin
      oram_output_ready <= 1'b0;
      prev_ir           <= oram_input_ready;
      if (oram_input_ready && prev_ir) pulse_err <= pulse_err + 1;
      if (oram_input_ready && !prev_ir) begin
        n_issue <= n_issue + 1;
        c_addr  <= oram_block_number;
        c_rw    <= oram_rw_indicator;
        if (oram_rw_indicator) core_mem[oram_block_number] <= oram_w_value;
        if (core_lat == 0) begin
          oram_output_ready <= 1'b1;
          oram_r_value <= oram_rw_indicator ? DW'($urandom) : core_mem[oram_block_number];
        end else begin
          c_busy <= 1'b1;
          c_cnt  <= core_lat - 1;
        end
      end else if (c_busy) begin
        if (oram_block_number != c_addr || oram_rw_indicator != c_rw) stab_err <= stab_err + 1;
        if (c_cnt == 0) begin
          oram_output_ready <= 1'b1;
          oram_r_value <= c_rw ? DW'($urandom) : core_mem[c_addr];
          c_busy <= 1'b0;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: responses come back in acceptance order; a read returns
  // the last value written to that block, a write returns 0.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic             rw;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    rdata;
  } rsp_t;

  rsp_t          expq [$];
  logic [DW-1:0] sh [16] = '{default: '0};

  // Called at a negedge with inputs already applied: handshakes that will
  // complete at the coming posedge are accounted for, then time advances.
  task automatic tick();
    rsp_t e;
    if (req_valid && req_ready) begin
      e.rw  = req_rw;
      e.tag = req_tag;
      if (req_rw) begin
        sh[req_addr] = req_wdata;
        e.rdata = '0;
      end else begin
        e.rdata = sh[req_addr];
      end
      expq.push_back(e);
    end
    if (resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("resp_order", 32'({resp_rw, resp_tag, resp_rdata}), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic             rw;
    logic [D-1:0]     addr;
    logic [DW-1:0]    wdata;
    logic [TAG_W-1:0] tag;
    logic             exp_rw;
    logic [TAG_W-1:0] exp_tag;
    logic [DW-1:0]    exp_rdata;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, acc, saw;
    logic [TAG_W+DW-1:0] snap;

    tbl[0] = '{1'b1, 4'h3, 16'hBEEF, 2'd1, 1'b1, 2'd1, 16'h0000};
    tbl[1] = '{1'b0, 4'h3, 16'h0000, 2'd2, 1'b0, 2'd2, 16'hBEEF};
    tbl[2] = '{1'b1, 4'hA, 16'h1234, 2'd3, 1'b1, 2'd3, 16'h0000};
    tbl[3] = '{1'b0, 4'hA, 16'h5555, 2'd0, 1'b0, 2'd0, 16'h1234};
    tbl[4] = '{1'b0, 4'h7, 16'hFFFF, 2'd1, 1'b0, 2'd1, 16'h0000};
    tbl[5] = '{1'b1, 4'h3, 16'hFFFF, 2'd2, 1'b1, 2'd2, 16'h0000};
    tbl[6] = '{1'b0, 4'h3, 16'h0000, 2'd3, 1'b0, 2'd3, 16'hFFFF};

    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0; resp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_oram_ir", oram_input_ready, 0);
    check("rst_oram_fields", {oram_block_number, oram_w_value, oram_rw_indicator}, 0);
    check("rst_resp_fields", {resp_rw, resp_tag, resp_rdata}, 0);

    // Latency of a single read into an idle, empty block
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'h5; req_tag = 2'd3;
    tick();
    req_valid = 1'b0;
    check("lat_e0_ir", oram_input_ready, 0);
    tick();
    check("lat_e1_ir", oram_input_ready, 1);
    check("lat_e1_addr", {oram_rw_indicator, oram_block_number}, {1'b0, 4'h5});
    tick();
    check("lat_e2_ir", oram_input_ready, 0);
    check("lat_e2_rv", resp_valid, 0);
    tick();
    check("lat_e3_rv", resp_valid, 1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      n0 = n_issue;
      req_valid = 1'b1; req_rw = tbl[i].rw; req_addr = tbl[i].addr;
      req_wdata = tbl[i].wdata; req_tag = tbl[i].tag;
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 30 && !resp_valid; k++) tick();
      check("tbl_valid", resp_valid, 1);
      check("tbl_resp", {resp_rw, resp_tag, resp_rdata},
            {tbl[i].exp_rw, tbl[i].exp_tag, tbl[i].exp_rdata});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("tbl_issue_count", n_issue - n0, 1);
    end

    // Back-to-back pushes with the response channel stalled
    acc = 0;
    for (int k = 0; k < 12 && acc < 5; k++) begin
      req_valid = 1'b1; req_rw = acc[0]; req_addr = 4'(acc + 8);
      req_wdata = 16'h1000 + 16'(acc); req_tag = 2'(acc);
      saw = int'(req_ready);
      tick();
      acc += saw;
    end
    req_valid = 1'b0;
    check("full_accepted", acc, 5);
    tick(); tick(); tick();
    check("full_ready_low", req_ready, 0);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'h8; req_tag = 2'd2;
    for (int k = 0; k < 3; k++) begin
      check("full_no_push", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) tick();
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 100 && expq.size() != 0; k++) tick();
    check("full_drain", expq.size(), 0);

    // Response held for 10 cycles with another request queued behind it
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'h3; req_tag = 2'd1;
    tick();
    req_addr = 4'hA; req_tag = 2'd2;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 30 && !resp_valid; k++) tick();
    check("hold_valid", resp_valid, 1);
    snap = {resp_tag, resp_rdata};
    n0 = n_issue;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_stable", {resp_valid, resp_tag, resp_rdata}, {1'b1, snap});
      check("hold_no_issue", n_issue, n0);
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 50 && expq.size() != 0; k++) tick();
    check("hold_drain", expq.size(), 0);
    check("hold_second_issue", n_issue - n0, 1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) core_lat = $urandom_range(0, 3);
      req_valid  = ($urandom_range(0, 2) != 0);
      req_rw     = 1'($urandom);
      req_addr   = 4'($urandom_range(0, 3));
      req_wdata  = DW'($urandom);
      req_tag    = TAG_W'($urandom);
      resp_ready = 1'($urandom);
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    for (int k = 0; k < 200 && expq.size() != 0; k++) tick();
    check("rand_drain", expq.size(), 0);

    // Reset while waiting on the core with two requests still queued
    core_lat = 12; resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'(k); req_tag = 2'(k);
      tick();
    end
    req_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    expq.delete();
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_outputs", {resp_valid, oram_input_ready, oram_rw_indicator,
                              oram_block_number, resp_tag}, 0);
    check("mid_rst_data", {oram_w_value, resp_rdata}, 0);
    @(negedge clk);
    core_lat = 0;
    rst = 1'b0;
    n0 = n_issue; saw = 0; resp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) saw++;
      tick();
    end
    check("post_rst_no_resp", saw, 0);
`ifdef ORAM_DUMMY_EN
    check("dummy_issue_count", n_issue - n0, 2);
`else
    check("idle_no_traffic", n_issue - n0, 0);
`endif

    check("ir_single_cycle", pulse_err, 0);
    check("oram_fields_stable", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
